// File: rtl/i281_pkg.sv
// i281_pkg: shared constants for the i281 instruction decoder.
//   - opcode nibble values (OP_NOOP .. OP_BRANCH)
//   - one-hot bit indices of the decoded opcode bus (IDX_NOOP .. IDX_BRGE)
//   - flag bit positions inside flags_reg (FLG_Z .. FLG_C)
//   - instruction field slice positions and bus widths
//   - decode FSM state type
package i281_pkg;

    // Instruction field slices (16-bit instruction word)
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RX_MSB  = 11;
    localparam int unsigned RX_LSB  = 10;
    localparam int unsigned RY_MSB  = 9;
    localparam int unsigned RY_LSB  = 8;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    localparam int unsigned ONEHOT_W = 23;
    localparam int unsigned OPBUS_W  = 27;

    // Opcode nibbles
    localparam logic [3:0] OP_NOOP   = 4'h0;
    localparam logic [3:0] OP_INPUT  = 4'h1;
    localparam logic [3:0] OP_MOVE   = 4'h2;
    localparam logic [3:0] OP_LOADI  = 4'h3;
    localparam logic [3:0] OP_ADD    = 4'h4;
    localparam logic [3:0] OP_ADDI   = 4'h5;
    localparam logic [3:0] OP_SUB    = 4'h6;
    localparam logic [3:0] OP_SUBI   = 4'h7;
    localparam logic [3:0] OP_LOAD   = 4'h8;
    localparam logic [3:0] OP_LOADF  = 4'h9;
    localparam logic [3:0] OP_STORE  = 4'hA;
    localparam logic [3:0] OP_STOREF = 4'hB;
    localparam logic [3:0] OP_SHIFT  = 4'hC;
    localparam logic [3:0] OP_CMP    = 4'hD;
    localparam logic [3:0] OP_JUMP   = 4'hE;
    localparam logic [3:0] OP_BRANCH = 4'hF;

    // One-hot bit indices
    localparam logic [4:0] IDX_NOOP    = 5'd0;
    localparam logic [4:0] IDX_INPUTC  = 5'd1;
    localparam logic [4:0] IDX_INPUTCF = 5'd2;
    localparam logic [4:0] IDX_INPUTD  = 5'd3;
    localparam logic [4:0] IDX_INPUTDF = 5'd4;
    localparam logic [4:0] IDX_MOVE    = 5'd5;
    localparam logic [4:0] IDX_LOADI   = 5'd6;
    localparam logic [4:0] IDX_ADD     = 5'd7;
    localparam logic [4:0] IDX_ADDI    = 5'd8;
    localparam logic [4:0] IDX_SUB     = 5'd9;
    localparam logic [4:0] IDX_SUBI    = 5'd10;
    localparam logic [4:0] IDX_LOAD    = 5'd11;
    localparam logic [4:0] IDX_LOADF   = 5'd12;
    localparam logic [4:0] IDX_STORE   = 5'd13;
    localparam logic [4:0] IDX_STOREF  = 5'd14;
    localparam logic [4:0] IDX_SHIFTL  = 5'd15;
    localparam logic [4:0] IDX_SHIFTR  = 5'd16;
    localparam logic [4:0] IDX_CMP     = 5'd17;
    localparam logic [4:0] IDX_JUMP    = 5'd18;
    localparam logic [4:0] IDX_BRE     = 5'd19;
    localparam logic [4:0] IDX_BRNE    = 5'd20;
    localparam logic [4:0] IDX_BRG     = 5'd21;
    localparam logic [4:0] IDX_BRGE    = 5'd22;

    // Flag bit positions in flags_reg
    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_O = 2;
    localparam int unsigned FLG_C = 3;

    typedef enum logic {StHold, StDecode} dec_state_e;

endpackage

// File: rtl/i281_onehot_dec.sv
// i281_onehot_dec: combinational opcode decoder.
// Ports:
//   opc     in  4   opcode nibble of the instruction
//   ry      in  2   RY field (selects sub-operation for INPUT/SHIFT/BRANCH)
//   onehot  out 23  one-hot opcode, exactly one bit set
//   illegal out 1   illegal encoding detected
// Macro I281_DECODE_ILLEGAL_TRAP_EN: when defined, SHIFT with RY[1]=1 and JUMP with
// RY!=00 are flagged illegal and decode as NOOP; otherwise illegal is always 0 and the
// extra RY bits are ignored.
module i281_onehot_dec
    import i281_pkg::*;
(
    input  logic [3:0]          opc,
    input  logic [1:0]          ry,
    output logic [ONEHOT_W-1:0] onehot,
    output logic                illegal
);

    logic [4:0] idx;

    always_comb begin
        idx     = IDX_NOOP;
        illegal = 1'b0;
        unique case (opc)
            OP_NOOP:   idx = IDX_NOOP;
            OP_INPUT:  idx = IDX_INPUTC + {3'b000, ry};
            OP_MOVE:   idx = IDX_MOVE;
            OP_LOADI:  idx = IDX_LOADI;
            OP_ADD:    idx = IDX_ADD;
            OP_ADDI:   idx = IDX_ADDI;
            OP_SUB:    idx = IDX_SUB;
            OP_SUBI:   idx = IDX_SUBI;
            OP_LOAD:   idx = IDX_LOAD;
            OP_LOADF:  idx = IDX_LOADF;
            OP_STORE:  idx = IDX_STORE;
            OP_STOREF: idx = IDX_STOREF;
            OP_SHIFT:  idx = ry[0] ? IDX_SHIFTR : IDX_SHIFTL;
            OP_CMP:    idx = IDX_CMP;
            OP_JUMP:   idx = IDX_JUMP;
            OP_BRANCH: idx = IDX_BRE + {3'b000, ry};
        endcase
`ifdef I281_DECODE_ILLEGAL_TRAP_EN
        if ((opc == OP_SHIFT && ry[1]) || (opc == OP_JUMP && ry != 2'b00)) begin
            illegal = 1'b1;
            idx     = IDX_NOOP;
        end
`endif
    end

    assign onehot = {{(ONEHOT_W - 1){1'b0}}, 1'b1} << idx;

endmodule

// File: rtl/instr_decode_unit.sv
// instr_decode_unit: instruction register, flags register and registered decode for the
// multicycle control FSM.
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   instr_in       IW   instruction word from code memory
//   ir_load        1    capture instr_in into IR
//   alu_flags      4    {C,O,N,Z} from the ALU
//   flags_load     1    capture alu_flags into flags_reg
//   opcode_out     27   {RX, RY, one-hot[22:0]}
//   imm_out        8    immediate field of the decoded instruction
//   flags_reg      4    Z,N,O,C at bits 0..3
//   decode_valid   1    opcode_out reflects the current IR
//   branch_taken   1    branch/jump condition of the decoded instruction
//   illegal        1    illegal encoding (only with I281_DECODE_ILLEGAL_TRAP_EN defined)
// Latency: ir_load edge -> IR; next edge (DECODE) -> opcode_out/imm_out/branch_taken.
module instr_decode_unit
    import i281_pkg::*;
#(
    parameter int unsigned IW        = 16,
    parameter bit          NOP_RESET = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [IW-1:0]       instr_in,
    input  logic                ir_load,
    input  logic [3:0]          alu_flags,
    input  logic                flags_load,
    output logic [OPBUS_W-1:0]  opcode_out,
    output logic [7:0]          imm_out,
    output logic [3:0]          flags_reg,
    output logic                decode_valid,
    output logic                branch_taken,
    output logic                illegal
);

    localparam logic [OPBUS_W-1:0] OPCODE_RST =
        NOP_RESET ? {{(OPBUS_W - 1){1'b0}}, 1'b1} : '0;

    dec_state_e          state_q;
    logic [IW-1:0]       ir_q;
    logic [3:0]          flags_q;
    logic [OPBUS_W-1:0]  opcode_q;
    logic [7:0]          imm_q;
    logic                valid_q;
    logic                branch_q;
    logic                illegal_q;

    logic [ONEHOT_W-1:0] onehot;
    logic                dec_illegal;
    logic                branch_d;

    i281_onehot_dec u_onehot_dec (
        .opc     (ir_q[OPC_MSB:OPC_LSB]),
        .ry      (ir_q[RY_MSB:RY_LSB]),
        .onehot  (onehot),
        .illegal (dec_illegal)
    );

    // Evaluated against flags_q as it stands during DECODE.
    assign branch_d = onehot[IDX_JUMP]
                    | (onehot[IDX_BRE]  &  flags_q[FLG_Z])
                    | (onehot[IDX_BRNE] & ~flags_q[FLG_Z])
                    | (onehot[IDX_BRG]  & ~flags_q[FLG_Z] & ~flags_q[FLG_N])
                    | (onehot[IDX_BRGE] & ~flags_q[FLG_N]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StHold;
            ir_q      <= '0;
            flags_q   <= '0;
            opcode_q  <= OPCODE_RST;
            imm_q     <= '0;
            valid_q   <= 1'b0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (flags_load) begin
                flags_q <= alu_flags;
            end
            if (state_q == StDecode) begin
                opcode_q <= {ir_q[RX_MSB:RX_LSB], ir_q[RY_MSB:RY_LSB], onehot};
                imm_q    <= ir_q[IMM_MSB:IMM_LSB];
                branch_q <= branch_d;
            end
            // A new ir_load always wins, so back-to-back loads keep the FSM in DECODE.
            if (ir_load) begin
                ir_q      <= instr_in;
                state_q   <= StDecode;
                valid_q   <= 1'b0;
                illegal_q <= 1'b0;
            end else if (state_q == StDecode) begin
                state_q   <= StHold;
                valid_q   <= 1'b1;
                illegal_q <= dec_illegal;
            end
        end
    end

    assign opcode_out   = opcode_q;
    assign imm_out      = imm_q;
    assign flags_reg    = flags_q;
    assign decode_valid = valid_q;
    assign branch_taken = branch_q;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_instr_decode_unit.sv
// Self-checking bench for instr_decode_unit: directed vector table, hand sequences for
// back-to-back loads, reset mid-decode and illegal trapping, an exhaustive opcode/RY sweep
// and randomized transactions, all checked against a reference model built from the
// instruction map.
module tb_instr_decode_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] instr_in;
    logic        ir_load;
    logic [3:0]  alu_flags;
    logic        flags_load;
    logic [26:0] opcode_out;
    logic [7:0]  imm_out;
    logic [3:0]  flags_reg;
    logic        decode_valid;
    logic        branch_taken;
    logic        illegal;

    int errors = 0;
    int checks = 0;
    logic [3:0] model_flags;

    instr_decode_unit #(.IW(16), .NOP_RESET(1'b1)) dut (
        .clock        (clock),
        .reset        (reset),
        .instr_in     (instr_in),
        .ir_load      (ir_load),
        .alu_flags    (alu_flags),
        .flags_load   (flags_load),
        .opcode_out   (opcode_out),
        .imm_out      (imm_out),
        .flags_reg    (flags_reg),
        .decode_valid (decode_valid),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  flags;
        logic [26:0] exp_op;
        logic [7:0]  exp_imm;
        logic        exp_bt;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ir_load (and optionally flags_load) for one edge.
    task automatic load(input logic [15:0] w, input logic [3:0] f, input logic fen);
        instr_in   = w;
        ir_load    = 1'b1;
        alu_flags  = f;
        flags_load = fen;
        if (fen) model_flags = f;
        step();
        ir_load    = 1'b0;
        flags_load = 1'b0;
    endtask

    // Reference model: instruction map expressed as arithmetic on the opcode number.
    function automatic bit ref_illegal(input logic [15:0] w);
`ifdef I281_DECODE_ILLEGAL_TRAP_EN
        int op = int'(w[15:12]);
        int ry = int'(w[9:8]);
        return (op == 12 && ry >= 2) || (op == 14 && ry != 0);
`else
        return (w === 16'hxxxx);
`endif
    endfunction

    function automatic int ref_idx(input logic [15:0] w);
        int op = int'(w[15:12]);
        int ry = int'(w[9:8]);
        if (ref_illegal(w)) return 0;
        if (op == 0) return 0;
        if (op == 1) return 1 + ry;
        if (op <= 11) return op + 3;
        if (op == 12) return 15 + (ry % 2);
        if (op == 13) return 17;
        if (op == 14) return 18;
        return 19 + ry;
    endfunction

    function automatic bit ref_branch(input int idx, input logic [3:0] f);
        bit z = f[0];
        bit n = f[1];
        case (idx)
            18:      return 1'b1;
            19:      return z;
            20:      return !z;
            21:      return !z && !n;
            22:      return !n;
            default: return 1'b0;
        endcase
    endfunction

    // Wait out the DECODE cycle and compare every output to the model.
    task automatic expect_decode(input string name, input logic [15:0] w);
        int          idx;
        logic [26:0] exp_op;
        idx    = ref_idx(w);
        exp_op = (27'(1) << idx) | {w[11:10], w[9:8], 23'd0};
        check({name, " dv_low"}, 32'(decode_valid), 32'd0);
        step();
        check({name, " dv"}, 32'(decode_valid), 32'd1);
        check({name, " opcode"}, 32'(opcode_out), 32'(exp_op));
        check({name, " onehot_count"}, 32'($countones(opcode_out[22:0])), 32'd1);
        check({name, " imm"}, 32'(imm_out), 32'(w[7:0]));
        check({name, " branch"}, 32'(branch_taken), 32'(ref_branch(idx, model_flags)));
        check({name, " illegal"}, 32'(illegal), 32'(ref_illegal(w)));
        check({name, " flags"}, 32'(flags_reg), 32'(model_flags));
    endtask

    initial begin
        vecs[0] = '{16'h4600, 4'b0000, 27'h3000080, 8'h00, 1'b0};  // ADD RX=01 RY=10
        vecs[1] = '{16'hF000, 4'b0001, 27'h0080000, 8'h00, 1'b1};  // BRE, Z=1
        vecs[2] = '{16'hF200, 4'b0010, 27'h1200000, 8'h00, 1'b0};  // BRG, N=1
        vecs[3] = '{16'hE010, 4'b0000, 27'h0040000, 8'h10, 1'b1};  // JUMP
        vecs[4] = '{16'hF100, 4'b0000, 27'h0900000, 8'h00, 1'b1};  // BRNE, Z=0
        vecs[5] = '{16'hF3A5, 4'b0001, 27'h1C00000, 8'hA5, 1'b1};  // BRGE, N=0
        vecs[6] = '{16'h1D00, 4'b0000, 27'h6800004, 8'h00, 1'b0};  // INPUTCF RX=11 RY=01

        reset       = 1'b1;
        instr_in    = '0;
        ir_load     = 1'b0;
        alu_flags   = '0;
        flags_load  = 1'b0;
        model_flags = '0;
        step();
        check("rst opcode", 32'(opcode_out), 32'h1);
        check("rst flags", 32'(flags_reg), 32'd0);
        check("rst dv", 32'(decode_valid), 32'd0);
        check("rst branch", 32'(branch_taken), 32'd0);
        check("rst illegal", 32'(illegal), 32'd0);
        reset = 1'b0;
        step();
        step();
        check("idle opcode", 32'(opcode_out), 32'h1);
        check("idle dv", 32'(decode_valid), 32'd0);

        // Directed table, flags loaded together with the instruction.
        for (int i = 0; i < 7; i++) begin
            load(vecs[i].instr, vecs[i].flags, 1'b1);
            check($sformatf("vec%0d dv_low", i), 32'(decode_valid), 32'd0);
            step();
            check($sformatf("vec%0d dv", i), 32'(decode_valid), 32'd1);
            check($sformatf("vec%0d opcode", i), 32'(opcode_out), 32'(vecs[i].exp_op));
            check($sformatf("vec%0d imm", i), 32'(imm_out), 32'(vecs[i].exp_imm));
            check($sformatf("vec%0d branch", i), 32'(branch_taken), 32'(vecs[i].exp_bt));
        end

        // Flags loaded a cycle ahead of the branch.
        alu_flags = 4'b0001; flags_load = 1'b1; model_flags = 4'b0001;
        step();
        flags_load = 1'b0;
        check("flags_reg", 32'(flags_reg), 32'h1);
        load(16'hF000, 4'h0, 1'b0);
        step();
        check("seq bre taken", 32'(branch_taken), 32'd1);
        alu_flags = 4'b0010; flags_load = 1'b1; model_flags = 4'b0010;
        step();
        flags_load = 1'b0;
        load(16'hF200, 4'h0, 1'b0);
        step();
        check("seq brg not taken", 32'(branch_taken), 32'd0);

        // Back-to-back loads: only the newest word decodes.
        load(16'h3105, 4'h0, 1'b0);
        check("b2b dv0", 32'(decode_valid), 32'd0);
        load(16'hE010, 4'h0, 1'b0);
        check("b2b dv1", 32'(decode_valid), 32'd0);
        step();
        check("b2b dv", 32'(decode_valid), 32'd1);
        check("b2b jump bit", 32'(opcode_out[18]), 32'd1);
        check("b2b onehot", 32'(opcode_out[22:0]), 32'h40000);
        check("b2b imm", 32'(imm_out), 32'h10);

        // Reset asserted during DECODE: outputs return to reset values immediately.
        load(16'hF3C3, 4'hF, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("mid rst opcode", 32'(opcode_out), 32'h1);
        check("mid rst imm", 32'(imm_out), 32'd0);
        check("mid rst flags", 32'(flags_reg), 32'd0);
        check("mid rst dv", 32'(decode_valid), 32'd0);
        check("mid rst branch", 32'(branch_taken), 32'd0);
        check("mid rst illegal", 32'(illegal), 32'd0);
        model_flags = '0;
        step();
        reset = 1'b0;
        step();
        check("post rst dv", 32'(decode_valid), 32'd0);
        check("post rst opcode", 32'(opcode_out), 32'h1);

`ifdef I281_DECODE_ILLEGAL_TRAP_EN
        load(16'hC200, 4'h0, 1'b0);
        step();
        check("trap illegal", 32'(illegal), 32'd1);
        check("trap noop", 32'(opcode_out[22:0]), 32'h1);
        load(16'h4600, 4'h0, 1'b0);
        check("trap clear", 32'(illegal), 32'd0);
        step();
`endif

        // Sweep every opcode and RY value with random RX, imm and flags.
        for (int op = 0; op < 16; op++) begin
            for (int ry = 0; ry < 4; ry++) begin
                logic [15:0] w;
                w = {op[3:0], 2'($urandom_range(0, 3)), ry[1:0], 8'($urandom)};
                load(w, 4'($urandom), 1'b1);
                expect_decode($sformatf("sweep op%0d ry%0d", op, ry), w);
            end
        end

        // Randomized transactions, with occasional back-to-back loads and idle gaps.
        for (int n = 0; n < 60; n++) begin
            logic [15:0] w;
            int          extra;
            w = 16'($urandom);
            load(w, 4'($urandom), 1'($urandom_range(0, 1)));
            extra = $urandom_range(0, 2);
            for (int k = 0; k < extra; k++) begin
                w = 16'($urandom);
                load(w, 4'h0, 1'b0);
            end
            expect_decode($sformatf("rand%0d", n), w);
            if ($urandom_range(0, 1) == 1) begin
                step();
                check($sformatf("rand%0d hold", n), 32'(decode_valid), 32'd1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_decode_unit.md
Name: instr_decode_unit

Overview:
- Producer side of the control FSM's decoder interface. Holds the instruction register (IR) and the flags register.
- Registers a fully decoded 27-bit opcode bus (23-bit one-hot opcode plus RX/RY fields), the 8-bit immediate, and the 4-bit flags register.
- Sits between the code memory / ALU and the multicycle control FSM, which consumes opcode_out and flags_reg.

Parameters:
- IW, 16, instruction width; fields: opcode[15:12], RX[11:10], RY[9:8], imm[7:0]
- NOP_RESET, 1, when 1, the reset value of opcode_out is the NOOP one-hot (bit0 = 1); when 0, opcode_out resets to all-zero

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- instr_in  input  IW  instruction word from code memory
- ir_load  input  1  capture instr_in into IR (FSM ID-state strobe)
- alu_flags  input  4  {C,O,N,Z} from ALU
- flags_load  input  1  capture alu_flags into flags_reg
- opcode_out  output  27  [22:0] one-hot opcode, [24:23] RY, [26:25] RX
- imm_out  output  8  IR immediate field
- flags_reg  output  4  bit0 Z, bit1 N, bit2 O, bit3 C
- decode_valid  output  1  high while opcode_out reflects the current IR
- branch_taken  output  1  registered branch condition for the current IR
- illegal  output  1  illegal-encoding flag (feature-gated; tied 0 when the feature is off)

Behaviour:
- Reset (async): IR = 0; imm_out = 0; flags_reg = 0; decode_valid = 0; branch_taken = 0; illegal = 0. opcode_out = 27'h1 when NOP_RESET = 1, otherwise 0.
- IR capture: on ir_load at posedge, IR <= instr_in. Next cycle decode_valid = 0. opcode_out, imm_out and branch_taken are updated the cycle after IR (2-cycle latency from ir_load). decode_valid = 1 from then until the next ir_load.
- Two-state decode FSM:
  - HOLD: decode_valid = 1.
  - DECODE: one cycle; the decode register is loaded from IR.
  - Transitions: ir_load in any state -> DECODE. DECODE -> HOLD.
- Back-to-back ir_load: IR takes the newest word; the FSM stays in DECODE; decode_valid stays 0.
- Opcode map (one-hot bit index):
  - 0000 -> 0 NOOP
  - 0001 -> 1..4 by RY: 00 INPUTC, 01 INPUTCF, 10 INPUTD, 11 INPUTDF
  - 0010 -> 5 MOVE; 0011 -> 6 LOADI/LOADP
  - 0100 -> 7 ADD; 0101 -> 8 ADDI; 0110 -> 9 SUB; 0111 -> 10 SUBI
  - 1000 -> 11 LOAD; 1001 -> 12 LOADF; 1010 -> 13 STORE; 1011 -> 14 STOREF
  - 1100 -> 15 SHIFTL when RY[0] = 0, 16 SHIFTR when RY[0] = 1
  - 1101 -> 17 CMP; 1110 -> 18 JUMP
  - 1111 -> 19..22 by RY: 00 BRE, 01 BRNE, 10 BRG, 11 BRGE
- Exactly one one-hot bit is set at all times after the first decode.
- Flags: flags_reg <= alu_flags on flags_load. flags_load and ir_load may coincide; both take effect.
- branch_taken, evaluated in DECODE against the flags_reg value current in that cycle:
  - BRE: Z
  - BRNE: !Z
  - BRG: !Z & !N
  - BRGE: !N
  - JUMP: 1
  - all other opcodes: 0
- Reset mid-DECODE: the decode is abandoned; the reset values above apply.

Optional Feature:
- Macro I281_DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - opcode 1100 with RY[1] = 1, or opcode 1110 with RY != 00, sets illegal = 1 in the cycle decode_valid rises.
  - The one-hot is forced to NOOP (bit0).
  - illegal clears on the next ir_load.
- Undefined: illegal tied 0; those encodings decode by the map above, ignoring the extra RY bits.

Decomposition:
- Package i281_pkg:
  - opcode nibble localparams (OP_NOOP .. OP_BRANCH)
  - one-hot index constants (IDX_NOOP = 0 .. IDX_BRGE = 22)
  - flag bit indices (FLG_Z = 0, FLG_N = 1, FLG_O = 2, FLG_C = 3)
  - field-slice constants
- Sub-module i281_onehot_dec: purely combinational, instruction word -> 23-bit one-hot plus illegal. The top level owns IR, flags, FSM and output registers.

Test Plan:
- Reset, no ir_load -> opcode_out = 27'h0000001, flags_reg = 0, decode_valid = 0.
- ir_load with instr_in = 16'h4600 (ADD RX = 01, RY = 10) -> two cycles later:
  - opcode_out[22:0] = 1 << 7
  - opcode_out[26:25] = 01, opcode_out[24:23] = 10
  - decode_valid = 1
- flags_load with alu_flags = 4'b0001, then ir_load with 16'hF000 (BRE) -> branch_taken = 1. Repeat with flags 4'b0010 and 16'hF200 (BRG) -> branch_taken = 0.
- ir_load on two consecutive cycles (16'h3105, then 16'hE010) -> decode_valid stays 0 until the JUMP decode; then bit18 = 1, imm_out = 8'h10.
- Sweep all 16 opcodes × 4 RY values -> exactly one one-hot bit matching the map.
- With I281_DECODE_ILLEGAL_TRAP_EN defined, 16'hC200 -> illegal = 1 and one-hot = NOOP; assert reset mid-DECODE -> all outputs at reset values the same cycle.
